// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencer for an external loadable up-counter.
// Loads the counter with a latched base value and enables counting until the
// count reaches a latched terminal value. It then pulses done, and either
// reloads (periodic mode) or returns to idle (one-shot mode).
// Optional feature: define COUNT_SEQ_PRESCALE_EN to add the presc input and a
// prescaler that thins out the counter enable.
module count_seq_ctrl #(
  parameter int WIDTH   = 5,
  parameter int EVT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [WIDTH-1:0]   base,
  input  logic [WIDTH-1:0]   term,
  input  logic [WIDTH-1:0]   cnt_val,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  output logic               cnt_load,
  output logic               cnt_enab,
  output logic [WIDTH-1:0]   cnt_ld_val,
  output logic               busy,
  output logic               done,
  output logic [EVT_W-1:0]   evt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic               mode_q, mode_d;
  logic [EVT_W-1:0]   evt_q, evt_d;
  logic               hit;
  logic               strobe;

  assign hit = (cnt_val == term_q);

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign strobe = (pcnt_q == presc);

  // Prescaler next value: cleared while loading, counts RUN cycles, wraps on strobe
  always_comb begin
    pcnt_d = pcnt_q;
    if (state_q == LOAD) begin
      pcnt_d = '0;
    end else if (state_q == RUN) begin
      pcnt_d = strobe ? '0 : pcnt_q + 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign strobe = 1'b1;
`endif

  // Next-state and output decode; stop always overrides both start and a hit
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    term_d   = term_q;
    mode_d   = mode_q;
    evt_d    = evt_q;
    cnt_load = 1'b0;
    cnt_enab = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          base_d  = base;
          term_d  = term;
          mode_d  = periodic;
          evt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (stop) begin
          state_d = IDLE;
        end else begin
          cnt_load = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (stop) begin
          state_d = IDLE;
        end else if (hit) begin
          done = 1'b1;
          if (evt_q != {EVT_W{1'b1}}) begin
            evt_d = evt_q + 1'b1;
          end
          state_d = mode_q ? LOAD : IDLE;
        end else begin
          cnt_enab = strobe;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      evt_q   <= evt_d;
    end
  end

  assign cnt_ld_val = base_q;
  assign evt_cnt    = evt_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: bench for count_seq_ctrl with an external counter model.
// Includes table-driven scenarios, hand-written corner sequences and a
// randomized run checked against a schedule-based reference model.
module tb_count_seq_ctrl;

  localparam int WIDTH   = 5;
  localparam int EVT_W   = 3;
  localparam int EVT_MAX = (1 << EVT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, periodic;
  logic [WIDTH-1:0] base, term, cnt_val;
  logic             cnt_load, cnt_enab, busy, done;
  logic [WIDTH-1:0] cnt_ld_val;
  logic [EVT_W-1:0] evt_cnt;
  logic [WIDTH-1:0] cntQ = '0;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic             per;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] t;
    int               stopOff;
    int               window;
    int               expFirstDone;
    int               expDones;
    int               expEvt;
    int               expLastBusy;
  } vec_t;

  vec_t vecs[5];

  count_seq_ctrl #(.WIDTH(WIDTH), .EVT_W(EVT_W), .PRESC_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
    .base       (base),
    .term       (term),
    .cnt_val    (cnt_val),
    .cnt_load   (cnt_load),
    .cnt_enab   (cnt_enab),
    .cnt_ld_val (cnt_ld_val),
    .busy       (busy),
    .done       (done),
    .evt_cnt    (evt_cnt)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Loadable up-counter that the sequencer drives; reset does not touch it
  always @(posedge clk) begin
    if (cnt_load) cntQ <= cnt_ld_val;
    else if (cnt_enab) cntQ <= cntQ + 1'b1;
  end

  assign cnt_val = cntQ;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic pe,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] t);
    @(negedge clk);
    start    = s;
    stop     = p;
    periodic = pe;
    base     = b;
    term     = t;
    #1;
  endtask

  // Main test sequence
  initial begin
    int firstDone, dones, lastBusy, prevEvt;
    bit mActive, mPer;
    int mOff, mD, mEvt;
    logic [WIDTH-1:0] mBase;
    logic eLoad, eEnab, eDone;

    vecs[0] = '{1'b0, 5'd3,  5'd7,  0, 12, 6, 1, 1, 6};
    vecs[1] = '{1'b1, 5'd0,  5'd3,  0, 17, 5, 3, 3, 17};
    vecs[2] = '{1'b0, 5'd30, 5'd1,  0, 8,  5, 1, 1, 5};
    vecs[3] = '{1'b1, 5'd9,  5'd9,  0, 9,  2, 4, 4, 9};
    vecs[4] = '{1'b0, 5'd0,  5'd10, 4, 8,  0, 0, 0, 4};

    rst_n = 1'b0; start = 0; stop = 0; periodic = 0; base = '0; term = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_load",  cnt_load, 0);
    checkOutput("rst_enab",  cnt_enab, 0);
    checkOutput("rst_done",  done, 0);
    checkOutput("rst_evt",   evt_cnt, 0);
    checkOutput("rst_ldval", cnt_ld_val, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven scenarios
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1, 0, vecs[v].per, vecs[v].b, vecs[v].t);
      checkOutput("tbl_idle_busy", busy, 0);
      firstDone = 0; dones = 0; lastBusy = 0;
      for (int off = 1; off <= vecs[v].window; off++) begin
        applyStimulus(0, off == vecs[v].stopOff, ~vecs[v].per, ~vecs[v].b, ~vecs[v].t);
        if (off == 1) begin
          checkOutput("tbl_load", cnt_load, 1);
          checkOutput("tbl_ldval", cnt_ld_val, vecs[v].b);
          checkOutput("tbl_load_enab", cnt_enab, 0);
        end
        if (off == vecs[v].stopOff) begin
          checkOutput("tbl_stop_enab", cnt_enab, 0);
          checkOutput("tbl_stop_done", done, 0);
        end
        if (done) begin
          dones++;
          if (firstDone == 0) firstDone = off;
        end
        if (busy) lastBusy = off;
      end
      checkOutput("tbl_first_done", firstDone, vecs[v].expFirstDone);
      checkOutput("tbl_dones", dones, vecs[v].expDones);
      checkOutput("tbl_evt", evt_cnt, vecs[v].expEvt);
      checkOutput("tbl_last_busy", lastBusy, vecs[v].expLastBusy);
      applyStimulus(0, 1, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      checkOutput("tbl_end_busy", busy, 0);
    end

    // start and stop together in IDLE: stop wins
    applyStimulus(1, 1, 0, 5'd2, 5'd4);
    applyStimulus(0, 0, 0, 5'd2, 5'd4);
    checkOutput("startstop_busy", busy, 0);
    checkOutput("startstop_load", cnt_load, 0);

    // Event counter saturation with a two-cycle periodic interval
    applyStimulus(1, 0, 1, 5'd9, 5'd9);
    prevEvt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, '0, '0);
      if (int'(evt_cnt) < prevEvt) checkOutput("sat_monotonic", evt_cnt, prevEvt);
      prevEvt = int'(evt_cnt);
    end
    checkOutput("sat_evt", evt_cnt, EVT_MAX);
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("sat_kept_after_stop", evt_cnt, EVT_MAX);
    applyStimulus(1, 0, 0, 5'd1, 5'd1);
    applyStimulus(0, 0, 0, 5'd1, 5'd1);
    checkOutput("sat_cleared_on_start", evt_cnt, 0);
    applyStimulus(0, 1, 0, '0, '0);

    // start while busy must not relatch configuration
    applyStimulus(1, 0, 0, 5'd0, 5'd4);
    firstDone = 0;
    for (int off = 1; off <= 7; off++) begin
      applyStimulus(1, 0, 1, 5'd10, 5'd12);
      if (done && firstDone == 0) firstDone = off;
      if (off == 7) checkOutput("relatch_busy_drop", busy, 0);
    end
    checkOutput("relatch_done_off", firstDone, 6);
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);

    // Asynchronous reset in the middle of RUN, then a fresh start
    applyStimulus(1, 0, 0, 5'd0, 5'd20);
    repeat (5) applyStimulus(0, 0, 0, 5'd0, 5'd20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_enab", cnt_enab, 0);
    checkOutput("arst_ldval", cnt_ld_val, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 5'd2, 5'd4);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("arst_fresh_load", cnt_load, 1);
    checkOutput("arst_fresh_ldval", cnt_ld_val, 2);
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("arst_fresh_done", done, 1);

    // Randomized run against a schedule model: offset 0 is the LOAD cycle,
    // offset d+1 is the hit cycle, where d = (term - base) mod 2^WIDTH
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mActive = 0; mPer = 0; mOff = 0; mD = 0; mEvt = 0; mBase = '0;
    for (int c = 0; c < 800; c++) begin
      logic rs, rp, rpe;
      logic [WIDTH-1:0] rb, rt;
      rs  = ($urandom % 4) == 0;
      rp  = ($urandom % 20) == 0;
      rpe = $urandom % 2;
      rb  = WIDTH'($urandom);
      rt  = (($urandom % 4) == 0) ? WIDTH'($urandom) : rb + WIDTH'($urandom_range(0, 5));
      applyStimulus(rs, rp, rpe, rb, rt);
      eLoad = mActive && mOff == 0 && !rp;
      eEnab = mActive && mOff >= 1 && mOff <= mD && !rp;
      eDone = mActive && mOff == mD + 1 && !rp;
      checkOutput("rnd_busy", busy, mActive);
      checkOutput("rnd_load", cnt_load, eLoad);
      checkOutput("rnd_enab", cnt_enab, eEnab);
      checkOutput("rnd_done", done, eDone);
      checkOutput("rnd_evt", evt_cnt, mEvt);
      if (eLoad) checkOutput("rnd_ldval", cnt_ld_val, mBase);
      if (mActive) begin
        if (rp) mActive = 0;
        else if (mOff == mD + 1) begin
          if (mEvt < EVT_MAX) mEvt++;
          if (mPer) mOff = 0;
          else mActive = 0;
        end else mOff++;
      end else if (rs && !rp) begin
        mActive = 1;
        mOff    = 0;
        mPer    = rpe;
        mBase   = rb;
        mD      = (int'(rt) - int'(rb) + (1 << WIDTH)) % (1 << WIDTH);
        mEvt    = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
